// File: rtl/router_pkt_rx.sv
// Input-side receiver of the 1x3 router: decodes the header, steers bytes through a 2-entry skid buffer into three FIFOs.
// Optional macro ROUTER_RX_PKT_CNT_EN adds saturating good/error packet counters (good_cnt, err_cnt).
module router_pkt_rx #(
    parameter int DW    = 8,
    parameter int NDEST = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DW-1:0]    d_in,
    input  logic             pkt_vld,
    output logic             busy,
    output logic             error,
    input  logic [NDEST-1:0] fifo_full,
    output logic [NDEST-1:0] wr_en,
    output logic [DW-1:0]    wr_data
`ifdef ROUTER_RX_PKT_CNT_EN
    ,
    output logic [15:0]      good_cnt,
    output logic [15:0]      err_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_PARITY, S_CHECK, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        dest_q, dest_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DW-1:0]     calc_par_q, calc_par_d;
    logic [DW-1:0]     rx_par_q, rx_par_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic [NDEST-1:0]  wr_en_q, wr_en_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;

    logic [DW-1:0]     buf_data_q [2];
    logic [DW-1:0]     buf_data_d [2];
    logic [1:0]        buf_dest_q [2];
    logic [1:0]        buf_dest_d [2];
    logic [1:0]        occ_q, occ_d;

    logic              accept;
    logic              in_wr;
    logic [1:0]        in_dest;
    logic              cand_vld;
    logic [DW-1:0]     cand_data;
    logic [1:0]        cand_dest;
    logic [NDEST-1:0]  dest_dec;
    logic              full_sel;
    logic              do_wr;
    logic              blocked;
    logic              pop;
    logic              push;
    logic              par_bad;

    assign accept  = pkt_vld && !busy_q;
    assign par_bad = (rx_par_q != calc_par_q);

    // Packet framing: decides which accepted bytes are forwarded and tracks parity.
    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        calc_par_d = calc_par_q;
        rx_par_d   = rx_par_q;
        error_d    = error_q;
        in_wr      = 1'b0;
        in_dest    = dest_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dest_d     = d_in[1:0];
                    len_d      = d_in[7:2];
                    cnt_d      = '0;
                    calc_par_d = d_in;
                    error_d    = 1'b0;
                    in_dest    = d_in[1:0];
                    if (d_in[1:0] == 2'd3) begin
                        state_d = S_DROP;
                    end else begin
                        in_wr   = 1'b1;
                        state_d = (d_in[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    in_wr      = 1'b1;
                    calc_par_d = calc_par_q ^ d_in;
                    cnt_d      = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == len_q) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (accept) begin
                    in_wr    = 1'b1;
                    rx_par_d = d_in;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                error_d = par_bad;
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_vld) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The write candidate is the buffer head, or the incoming byte bypassing an empty buffer.
    assign cand_vld  = (occ_q != 2'd0) || in_wr;
    assign cand_data = (occ_q != 2'd0) ? buf_data_q[0] : d_in;
    assign cand_dest = (occ_q != 2'd0) ? buf_dest_q[0] : in_dest;

    genvar gi;
    generate
        for (gi = 0; gi < NDEST; gi++) begin : g_dest
            assign dest_dec[gi] = (cand_dest == 2'(gi));
        end
    endgenerate

    assign full_sel = |(fifo_full & dest_dec);
    assign do_wr    = cand_vld && !full_sel;
    assign blocked  = cand_vld && full_sel;
    assign pop      = do_wr && (occ_q != 2'd0);
    assign push     = in_wr && !(do_wr && (occ_q == 2'd0));

    always_comb begin
        buf_data_d[0] = buf_data_q[0];
        buf_data_d[1] = buf_data_q[1];
        buf_dest_d[0] = buf_dest_q[0];
        buf_dest_d[1] = buf_dest_q[1];
        occ_d         = occ_q;
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_dest_d[0] = buf_dest_q[1];
            occ_d         = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_d == 2'd0) begin
                buf_data_d[0] = d_in;
                buf_dest_d[0] = in_dest;
            end else begin
                buf_data_d[1] = d_in;
                buf_dest_d[1] = in_dest;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    // busy is registered, so one extra byte may still land after a stall; entry 1 absorbs it.
    assign busy_d    = blocked || (occ_d == 2'd2) || (state_d == S_CHECK);
    assign wr_en_d   = do_wr ? dest_dec : '0;
    assign wr_data_d = do_wr ? cand_data : wr_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            dest_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            calc_par_q    <= '0;
            rx_par_q      <= '0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            wr_en_q       <= '0;
            wr_data_q     <= '0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_dest_q[0] <= '0;
            buf_dest_q[1] <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            calc_par_q    <= calc_par_d;
            rx_par_q      <= rx_par_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            buf_data_q[0] <= buf_data_d[0];
            buf_data_q[1] <= buf_data_d[1];
            buf_dest_q[0] <= buf_dest_d[0];
            buf_dest_q[1] <= buf_dest_d[1];
            occ_q         <= occ_d;
        end
    end

    assign busy    = busy_q;
    assign error   = error_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;

`ifdef ROUTER_RX_PKT_CNT_EN
    logic [15:0] good_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (state_q == S_CHECK) begin
            if (par_bad) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
                if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule
